// File: rtl/crc32_stream.sv
// crc32_stream: streaming Ethernet CRC-32 with TX FCS append or RX residue check
module crc32_stream #(
  parameter int DW         = 2,
  parameter bit APPEND_FCS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic [31:0]   fcs_out,
  output logic          fcs_valid,
  output logic          crc_ok
);
  localparam int NB = 32 / DW;
  localparam int CW = $clog2(NB);
  typedef enum logic [1:0] {IDLE, DATA, FCS} state_t;
  state_t state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_next, shift_q, shift_d, fcs_q, fcs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fcs_valid_q, fcs_valid_d, crc_ok_q, crc_ok_d, accept, fcs_last;
  // Fold one beat into the CRC; a new frame always starts from the all-ones seed
  always_comb begin
    crc_next = (state_q == IDLE) ? 32'hFFFFFFFF : crc_q;
    for (int i = 0; i < DW; i++)
      crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ in_data[i]) ? 32'hEDB88320 : 32'h0);
  end
  // Pass-through datapath, switched to the FCS shifter while appending
  always_comb begin
    fcs_last  = cnt_q == CW'(NB - 1);
    in_ready  = (state_q == FCS) ? 1'b0 : out_ready;
    out_valid = (state_q == FCS) ? 1'b1 : in_valid;
    out_data  = (state_q == FCS) ? shift_q[DW-1:0] : in_data;
    out_last  = (state_q == FCS) ? fcs_last : (!APPEND_FCS && in_last);
    accept    = in_valid && in_ready;
  end
  // Next-state: accumulate, close the frame, then shift out the FCS in TX
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    fcs_d       = fcs_q;
    fcs_valid_d = 1'b0;
    crc_ok_d    = crc_ok_q;
    if (state_q == FCS) begin
      if (out_ready) begin
        shift_d = shift_q >> DW;
        cnt_d   = cnt_q + 1'b1;
        if (fcs_last) begin
          state_d = IDLE;
          crc_d   = 32'hFFFFFFFF;
        end
      end
    end else if (accept) begin
      state_d = DATA;
      crc_d   = crc_next;
      if (in_last) begin
        fcs_d       = ~crc_next;
        fcs_valid_d = 1'b1;
        if (APPEND_FCS) begin
          state_d = FCS;
          cnt_d   = '0;
          shift_d = ~crc_next;
        end else begin
          state_d  = IDLE;
          crc_d    = 32'hFFFFFFFF;
          crc_ok_d = crc_next == 32'hDEBB20E3;
        end
      end
    end
  end
  // State registers; reset discards any partial frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_q       <= 32'hFFFFFFFF;
      cnt_q       <= '0;
      shift_q     <= '0;
      fcs_q       <= '0;
      fcs_valid_q <= 1'b0;
      crc_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      fcs_q       <= fcs_d;
      fcs_valid_q <= fcs_valid_d;
      crc_ok_q    <= crc_ok_d;
    end
  end
  assign fcs_out   = fcs_q;
  assign fcs_valid = fcs_valid_q;
  assign crc_ok    = crc_ok_q;
endmodule

// File: tb/tb_crc32_stream.sv
// tb_crc32_stream: directed vector bench over TX/RX instances of several beat widths
module tb_crc32_stream;
  localparam logic [127:0] S9 = 128'h39_38_37_36_35_34_33_32_31;
  localparam logic [127:0] SF = 128'hCB_F4_39_26_39_38_37_36_35_34_33_32_31;
  localparam logic [127:0] SB = 128'hCB_F4_39_26_39_38_37_36_34_34_33_32_31;
  typedef struct {
    int          k;
    logic [127:0] data;
    int          nbits;
    bit          gaps;
    logic [31:0] exp_fcs;
    bit          chk_fcs;
    bit          exp_ok;
    bit          toggle;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] iv = '0, il = '0, ordy = '1;
  logic [7:0] id0 = '0;
  logic [1:0] id1 = '0, id2 = '0;
  logic [3:0] id3 = '0;
  logic       id4 = 1'b0;
  wire  [4:0] ov, ol, ir, fv, ok;
  wire  [7:0] od0;
  wire  [1:0] od1, od2;
  wire  [3:0] od3;
  wire        od4;
  wire  [31:0] fcs0, fcs1, fcs2, fcs3, fcs4;
  int checks = 0, errors = 0;
  int pulses [5] = '{default: 0};
  vec_t tbl [9];

  always #5 clk = ~clk;

  crc32_stream #(.DW(8), .APPEND_FCS(1'b1)) u0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id0), .in_last(il[0]),
    .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od0), .out_last(ol[0]), .out_ready(ordy[0]), .fcs_out(fcs0), .fcs_valid(fv[0]), .crc_ok(ok[0]));
  crc32_stream #(.DW(2), .APPEND_FCS(1'b0)) u1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id1), .in_last(il[1]),
    .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od1), .out_last(ol[1]), .out_ready(ordy[1]), .fcs_out(fcs1), .fcs_valid(fv[1]), .crc_ok(ok[1]));
  crc32_stream #(.DW(2), .APPEND_FCS(1'b1)) u2 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(id2), .in_last(il[2]),
    .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od2), .out_last(ol[2]), .out_ready(ordy[2]), .fcs_out(fcs2), .fcs_valid(fv[2]), .crc_ok(ok[2]));
  crc32_stream #(.DW(4), .APPEND_FCS(1'b1)) u3 (.clk(clk), .rst(rst), .in_valid(iv[3]), .in_data(id3), .in_last(il[3]),
    .in_ready(ir[3]), .out_valid(ov[3]), .out_data(od3), .out_last(ol[3]), .out_ready(ordy[3]), .fcs_out(fcs3), .fcs_valid(fv[3]), .crc_ok(ok[3]));
  crc32_stream #(.DW(1), .APPEND_FCS(1'b0)) u4 (.clk(clk), .rst(rst), .in_valid(iv[4]), .in_data(id4), .in_last(il[4]),
    .in_ready(ir[4]), .out_valid(ov[4]), .out_data(od4), .out_last(ol[4]), .out_ready(ordy[4]), .fcs_out(fcs4), .fcs_valid(fv[4]), .crc_ok(ok[4]));

  always @(posedge clk)
    for (int k = 0; k < 5; k++)
      if (fv[k]) pulses[k] <= pulses[k] + 1;

  function automatic int dwof(int k);
    return (k == 0) ? 8 : (k == 3) ? 4 : (k == 4) ? 1 : 2;
  endfunction

  function automatic bit is_tx(int k);
    return (k == 0) || (k == 2) || (k == 3);
  endfunction

  function automatic logic [7:0] get_od(int k);
    case (k)
      0:       return od0;
      1:       return {6'b0, od1};
      2:       return {6'b0, od2};
      3:       return {4'b0, od3};
      default: return {7'b0, od4};
    endcase
  endfunction

  function automatic logic [31:0] get_fcs(int k);
    case (k)
      0:       return fcs0;
      1:       return fcs1;
      2:       return fcs2;
      3:       return fcs3;
      default: return fcs4;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(int k, logic v, logic [7:0] d, logic l);
    iv[k] = v;
    il[k] = l;
    case (k)
      0:       id0 = d;
      1:       id1 = d[1:0];
      2:       id2 = d[1:0];
      3:       id3 = d[3:0];
      default: id4 = d[0];
    endcase
  endtask

  task automatic send_frame(int k, logic [127:0] data, int nbits, bit gaps);
    int dw = dwof(k);
    int nb = nbits / dw;
    int bad = 0;
    logic [127:0] mask = (128'd1 << dw) - 128'd1;
    logic [7:0] beat;
    for (int b = 0; b < nb; b++) begin
      if (gaps && (b == 5 || $urandom_range(0, 7) == 0)) begin
        drive(k, 1'b0, 8'h0, 1'b0);
        repeat (3) @(negedge clk);
      end
      beat = 8'((data >> (b * dw)) & mask);
      drive(k, 1'b1, beat, b == nb - 1);
      #1;
      if (!ir[k] || !ov[k] || get_od(k) !== beat || ol[k] !== (!is_tx(k) && il[k])) bad++;
      @(posedge clk);
      @(negedge clk);
    end
    drive(k, 1'b0, 8'h0, 1'b0);
    chk("passthru", bad, 0);
  endtask

  task automatic collect_fcs(int k, logic [31:0] exp, bit toggle);
    int dw = dwof(k);
    int n = 32 / dw;
    int got = 0, cyc = 0, bad = 0;
    logic [7:0] eb;
    while (got < n && cyc < 4 * n) begin
      if (toggle) ordy[k] = (cyc % 2 == 0);
      #1;
      eb = 8'((exp >> (got * dw)) & ((32'd1 << dw) - 32'd1));
      if (!ov[k] || ir[k] || get_od(k) !== eb || ol[k] !== (got == n - 1)) bad++;
      if (ordy[k]) got++;
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    ordy[k] = 1'b1;
    chk("fcs_beats", got, n);
    chk("fcs_beat_data", bad, 0);
    chk("fcs_cycles", cyc, toggle ? 2 * n - 1 : n);
    #1;
    chk("idle_after_fcs", {ov[k], ir[k]}, 2'b01);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, S9, 72, 1'b0, 32'hCBF43926, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1, SF, 104, 1'b0, 32'h2144DF1C, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1, SB, 104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1, SF, 104, 1'b0, 32'h2144DF1C, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{2, S9, 72, 1'b0, 32'hCBF43926, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{3, S9, 72, 1'b0, 32'hCBF43926, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{3, 128'h0, 4, 1'b0, 32'h4DBDF21C, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{4, SF, 104, 1'b0, 32'h2144DF1C, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{4, SF, 104, 1'b1, 32'h2144DF1C, 1'b1, 1'b1, 1'b0};
    ordy = 5'b11101;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("rst_fcs_out", get_fcs(k), 32'h0);
      chk("rst_flags", {fv[k], ok[k], ov[k], ol[k]}, 4'b0000);
      chk("rst_in_ready", ir[k], ordy[k]);
    end
    ordy = '1;
    rst = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 9; t++) begin
      send_frame(tbl[t].k, tbl[t].data, tbl[t].nbits, tbl[t].gaps);
      #1;
      chk("fcs_valid", fv[tbl[t].k], 1'b1);
      if (tbl[t].chk_fcs) chk("fcs_out", get_fcs(tbl[t].k), tbl[t].exp_fcs);
      chk("crc_ok", ok[tbl[t].k], tbl[t].exp_ok);
      if (is_tx(tbl[t].k)) collect_fcs(tbl[t].k, tbl[t].exp_fcs, tbl[t].toggle);
    end
    repeat (2) @(negedge clk);
    chk("pulses_k0", pulses[0], 1);
    chk("pulses_k1", pulses[1], 3);
    chk("pulses_k2", pulses[2], 1);
    chk("pulses_k3", pulses[3], 2);
    chk("pulses_k4", pulses[4], 2);
    for (int b = 0; b < 4; b++) begin
      drive(0, 1'b1, 8'h31 + 8'(b), 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    drive(0, 1'b0, 8'h0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_fcs_out", fcs0, 32'h0);
    chk("midrst_flags", {fv[0], ok[0], ov[0], ol[0], ir[0]}, 5'b00001);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_pulse", pulses[0], 1);
    send_frame(0, S9, 72, 1'b0);
    #1;
    chk("post_rst_fcs_out", fcs0, 32'hCBF43926);
    collect_fcs(0, 32'hCBF43926, 1'b0);
    repeat (2) @(negedge clk);
    chk("post_rst_pulses", pulses[0], 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
